// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller: state encoding,
// datapath width, default memory latency and small request helpers.
package mem_pkg;

    localparam int DATA_W          = 16;
    localparam int MEM_LAT_DEFAULT = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Byte stores replicate the low byte so the memory can pick either lane.
    function automatic logic [DATA_W-1:0] store_data(
        input logic              word,
        input logic [DATA_W-1:0] wdata
    );
        return word ? wdata : {wdata[7:0], wdata[7:0]};
    endfunction

    function automatic logic misaligned(
        input logic              word,
        input logic [DATA_W-1:0] addr
    );
        return word & addr[0];
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-request memory access controller: accepts one load/store, holds the
// memory interface for MEM_LAT cycles, then returns a one-cycle response.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_word,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we_n,
    output logic              mem_word,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              word_q,  word_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;

    // NOTE: every register is reset because its reset value is observable on
    // the memory and response ports; non-blocking assignments keep all
    // registers updating from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            word_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: each _d starts as its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    write_d = req_write;
                    word_d  = req_word;
                    wdata_d = store_data(req_word, req_wdata);
                    if (misaligned(req_word, req_addr)) begin
                        state_d = RESP;
                        cnt_d   = '0;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    rdata_d = write_q ? '0 : mem_rdata;
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The counter still holds its load value only in the first ACCESS cycle;
    // decoding we from state keeps it deasserting as soon as reset hits.
    assign mem_we_n   = !((state_q == ACCESS) && write_q && (cnt_q == CNT_LOAD));
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_word   = word_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_mem_access_ctrl;

    localparam int MEM_LAT = 2;
    localparam int BOUND   = 40;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_word;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we_n;
    logic        mem_word;
    logic [15:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          lat;
        int          we_low;
        logic [15:0] rdata;
        logic        err;
        logic        word;
        logic [15:0] wdata;
        logic        addr_bad;
        logic        pulse_bad;
        logic        hold_bad;
        logic        timeout;
    } obs_t;

    typedef struct {
        int          lat;
        int          we_low;
        logic [15:0] rdata;
        logic        err;
        logic [15:0] wdata;
    } exp_t;

    mem_access_ctrl #(.MEM_LAT(MEM_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_word  (req_word),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we_n  (mem_we_n),
        .mem_word  (mem_word),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level view of what one request must produce.
    function automatic exp_t model(input logic w, input logic word,
                                   input logic [15:0] addr, input logic [15:0] wdata,
                                   input logic [15:0] rdval);
        exp_t e;
        bit   bad;
        bad      = word && (addr % 2 == 1);
        e.lat    = bad ? 1 : MEM_LAT + 1;
        e.we_low = (!bad && w) ? 1 : 0;
        e.rdata  = (bad || w) ? 16'h0000 : rdval;
        e.err    = bad;
        e.wdata  = word ? wdata : 16'((wdata & 16'h00FF) * 16'h0101);
        return e;
    endfunction

    // Drives one request, then records what the DUT does until the response.
    task automatic do_txn(input logic w, input logic word, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rdval,
                          output obs_t o);
        int guard;
        o = '{lat: 0, we_low: 0, rdata: 16'h0, err: 1'b0, word: 1'b0, wdata: 16'h0,
              addr_bad: 1'b0, pulse_bad: 1'b0, hold_bad: 1'b0, timeout: 1'b0};
        @(negedge clk);
        mem_rdata = rdval;
        req_valid = 1'b1;
        req_write = w;
        req_word  = word;
        req_addr  = addr;
        req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < BOUND) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= BOUND) begin
            o.timeout = 1'b1;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_word  = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        for (int cyc = 1; cyc <= BOUND; cyc++) begin
            if (!mem_we_n) o.we_low++;
            if (cyc == 1) begin
                o.word  = mem_word;
                o.wdata = mem_wdata;
            end
            if (resp_valid) begin
                o.lat   = cyc;
                o.rdata = resp_rdata;
                o.err   = resp_err;
                break;
            end
            if (mem_addr !== addr || mem_word !== word) o.addr_bad = 1'b1;
            @(negedge clk);
        end
        if (o.lat == 0) begin
            o.timeout = 1'b1;
            return;
        end
        @(negedge clk);
        if (!mem_we_n) o.we_low++;
        o.pulse_bad = (resp_valid !== 1'b0);
        o.hold_bad  = (resp_rdata !== o.rdata) || (resp_err !== o.err);
    endtask

    task automatic test_reset();
        req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0; mem_rdata = 16'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
        checks++; if (resp_rdata !== 16'h0) begin errors++; $display("FAIL reset_resp_rdata got=%h want=0000", resp_rdata); end
        checks++; if (mem_we_n !== 1'b1) begin errors++; $display("FAIL reset_mem_we_n got=%b want=1", mem_we_n); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got=%h want=0000", mem_addr); end
        checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h want=0000", mem_wdata); end
        checks++; if (mem_word !== 1'b0) begin errors++; $display("FAIL reset_mem_word got=%b want=0", mem_word); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_word_load();
        obs_t o;
        do_txn(1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, o);
        checks++; if (o.timeout) begin errors++; $display("FAIL wload_timeout got=1 want=0"); end
        checks++; if (o.lat != 3) begin errors++; $display("FAIL wload_latency got=%0d want=3", o.lat); end
        checks++; if (o.rdata !== 16'hBEEF) begin errors++; $display("FAIL wload_rdata got=%h want=beef", o.rdata); end
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL wload_err got=%b want=0", o.err); end
        checks++; if (o.word !== 1'b1 || o.addr_bad) begin errors++; $display("FAIL wload_mem_word_addr word=%b addr_bad=%b want word=1 addr_bad=0", o.word, o.addr_bad); end
        checks++; if (o.we_low != 0) begin errors++; $display("FAIL wload_we got=%0d want=0", o.we_low); end
    endtask

    task automatic test_byte_store();
        obs_t o;
        do_txn(1'b1, 1'b0, 16'h0011, 16'h12A5, 16'h7777, o);
        checks++; if (o.wdata !== 16'hA5A5) begin errors++; $display("FAIL bstore_wdata got=%h want=a5a5", o.wdata); end
        checks++; if (o.word !== 1'b0) begin errors++; $display("FAIL bstore_mem_word got=%b want=0", o.word); end
        checks++; if (o.we_low != 1) begin errors++; $display("FAIL bstore_we_cycles got=%0d want=1", o.we_low); end
        checks++; if (o.rdata !== 16'h0 || o.err !== 1'b0) begin errors++; $display("FAIL bstore_resp rdata=%h err=%b want 0000/0", o.rdata, o.err); end
        checks++; if (o.lat != 3 || o.pulse_bad) begin errors++; $display("FAIL bstore_timing lat=%0d pulse_bad=%b want 3/0", o.lat, o.pulse_bad); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_txn(1'b0, 1'b1, 16'h0021, 16'h0000, 16'h5555, o);
        checks++; if (o.lat != 1) begin errors++; $display("FAIL misal_latency got=%0d want=1", o.lat); end
        checks++; if (o.err !== 1'b1 || o.rdata !== 16'h0) begin errors++; $display("FAIL misal_resp err=%b rdata=%h want 1/0000", o.err, o.rdata); end
        checks++; if (o.we_low != 0) begin errors++; $display("FAIL misal_we got=%0d want=0", o.we_low); end
        do_txn(1'b1, 1'b1, 16'h1233, 16'hCAFE, 16'h0000, o);
        checks++; if (o.we_low != 0 || o.err !== 1'b1 || o.lat != 1) begin errors++; $display("FAIL misal_store we=%0d err=%b lat=%0d want 0/1/1", o.we_low, o.err, o.lat); end
        checks++; if (o.hold_bad || o.pulse_bad) begin errors++; $display("FAIL misal_hold hold_bad=%b pulse_bad=%b want 0/0", o.hold_bad, o.pulse_bad); end
    endtask

    task automatic test_byte_load();
        obs_t o;
        do_txn(1'b0, 1'b0, 16'h0004, 16'h0000, 16'hFF80, o);
        checks++; if (o.rdata !== 16'hFF80 || o.err !== 1'b0) begin errors++; $display("FAIL bload_resp rdata=%h err=%b want ff80/0", o.rdata, o.err); end
        checks++; if (o.lat != 3 || o.hold_bad) begin errors++; $display("FAIL bload_timing lat=%0d hold_bad=%b want 3/0", o.lat, o.hold_bad); end
    endtask

    task automatic test_back_to_back();
        int accept2;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1;
        req_addr = 16'h0100; req_wdata = 16'h1111;
        @(posedge clk);
        accept2 = -1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                req_addr = 16'h0200; req_wdata = 16'h2222;
            end
            if (cyc <= 3) begin
                checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_c%0d got=%b want=0", cyc, req_ready); end
            end
            if (accept2 < 0 && req_ready === 1'b1) accept2 = cyc;
            if (cyc == 5) begin
                checks++; if (mem_wdata !== 16'h2222 || mem_we_n !== 1'b0) begin errors++; $display("FAIL b2b_second_store wdata=%h we_n=%b want 2222/0", mem_wdata, mem_we_n); end
                req_valid = 1'b0;
            end
        end
        checks++; if (accept2 != 4) begin errors++; $display("FAIL b2b_accept_edge got=%0d want=4", accept2); end
        for (int g = 0; g < BOUND && !req_ready; g++) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        bit seen;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1;
        req_addr = 16'h0040; req_wdata = 16'h9999;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_we_n !== 1'b0) begin errors++; $display("FAIL abort_we_active got=%b want=0", mem_we_n); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (mem_we_n !== 1'b1) begin errors++; $display("FAIL abort_we_async got=%b want=1", mem_we_n); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b want=1", req_ready); end
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (resp_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen) begin errors++; $display("FAIL abort_resp_valid got=1 want=0"); end
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic        w, word;
        logic [15:0] addr, wdata, rdval;
        for (int n = 0; n < 40; n++) begin
            w     = 1'($urandom);
            word  = 1'($urandom);
            addr  = 16'($urandom);
            wdata = 16'($urandom);
            rdval = 16'($urandom);
            e = model(w, word, addr, wdata, rdval);
            do_txn(w, word, addr, wdata, rdval, o);
            checks++;
            if (o.timeout || o.lat != e.lat || o.we_low != e.we_low ||
                o.rdata !== e.rdata || o.err !== e.err || o.pulse_bad || o.hold_bad) begin
                errors++;
                $display("FAIL rand_%0d resp lat=%0d/%0d we=%0d/%0d rdata=%h/%h err=%b/%b pulse_bad=%b hold_bad=%b to=%b (got/want)",
                         n, o.lat, e.lat, o.we_low, e.we_low, o.rdata, e.rdata, o.err, e.err,
                         o.pulse_bad, o.hold_bad, o.timeout);
            end
            if (!e.err) begin
                checks++;
                if (o.wdata !== e.wdata || o.word !== word || o.addr_bad) begin
                    errors++;
                    $display("FAIL rand_%0d mem wdata=%h/%h word=%b/%b addr_bad=%b (got/want)",
                             n, o.wdata, e.wdata, o.word, word, o.addr_bad);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_misaligned();
        test_byte_load();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
